wb_stage: RTL

Writeback stage of the five-stage LC-3b pipeline, directly downstream of the memory stage. Holds the MEM/WB pipeline register, selects the value written to the register file, performs the register-file write and owns the architectural condition-code register that the memory stage's branch comparator reads. It also drives a single-stage forwarding port so earlier stages can bypass the value about to be written.

---
 rtl/wb_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// LC-3b writeback stage: MEM/WB register, register-file write select, architectural CC register
// and forwarding port. Define WB_PERF_CNT_EN to build the retire/bubble counters.
package lc3b_pkg;
  typedef enum logic [3:0] {
    op_br   = 4'd0,
    op_add  = 4'd1,
    op_ldb  = 4'd2,
    op_stb  = 4'd3,
    op_jsr  = 4'd4,
    op_and  = 4'd5,
    op_ldr  = 4'd6,
    op_str  = 4'd7,
    op_rti  = 4'd8,
    op_not  = 4'd9,
    op_ldi  = 4'd10,
    op_sti  = 4'd11,
    op_jmp  = 4'd12,
    op_shf  = 4'd13,
    op_lea  = 4'd14,
    op_trap = 4'd15
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       load_regfile;
    logic       load_cc;
  } lc3b_control_word;
endpackage

module wb_stage
  import lc3b_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_wb,
  input  logic                flush,
  input  logic                valid_in,
  input  lc3b_control_word    cw_in,
  input  logic [15:0]         address_in,
  input  logic [15:0]         data_in,
  input  logic [15:0]         result_in,
  input  logic [15:0]         new_pc_in,
  input  logic [2:0]          dr_in,
  output logic                regfile_we,
  output logic [2:0]          regfile_dest,
  output logic [15:0]         regfile_data,
  output logic [2:0]          cc_out,
  output logic                fwd_valid,
  output logic [2:0]          fwd_dr,
  output logic [15:0]         fwd_data,
  output logic                wb_valid,
  output logic [RETIRE_W-1:0] retire_count,
  output logic [RETIRE_W-1:0] bubble_count
);

  logic             valid_q;
  lc3b_control_word cw_q;
  logic [15:0]      address_q, data_q, result_q, new_pc_q;
  logic [2:0]       dr_q;
  logic [2:0]       cc_q, cc_d;

  // WB never stalls: validity is recomputed every edge, payload only moves on load_wb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      cw_q      <= '0;
      address_q <= '0;
      data_q    <= '0;
      result_q  <= '0;
      new_pc_q  <= '0;
      dr_q      <= '0;
      cc_q      <= 3'b010;
    end else begin
      valid_q <= valid_in & load_wb & ~flush;
      cc_q    <= cc_d;
      if (load_wb) begin
        cw_q      <= cw_in;
        address_q <= address_in;
        data_q    <= data_in;
        result_q  <= result_in;
        new_pc_q  <= new_pc_in;
        dr_q      <= dr_in;
      end
    end
  end

  always_comb begin
    regfile_data = result_q;
    regfile_dest = dr_q;
    case (cw_q.opcode)
      op_ldr, op_ldi: regfile_data = data_q;
      op_ldb:         regfile_data = {8'h00, data_q[7:0]};
      op_jsr, op_trap: begin
        regfile_data = new_pc_q;
        regfile_dest = 3'd7;
      end
      op_lea:         regfile_data = address_q;
      default:        regfile_data = result_q;
    endcase
  end

  always_comb begin
    cc_d = cc_q;
    if (valid_q && cw_q.load_cc) begin
      if (regfile_data[15])           cc_d = 3'b100;
      else if (regfile_data == 16'h0) cc_d = 3'b010;
      else                            cc_d = 3'b001;
    end
  end

  assign regfile_we = valid_q & cw_q.load_regfile;
  assign cc_out     = cc_q;
  assign wb_valid   = valid_q;
  assign fwd_valid  = regfile_we;
  assign fwd_dr     = regfile_dest;
  assign fwd_data   = regfile_data;

`ifdef WB_PERF_CNT_EN
  logic [RETIRE_W-1:0] retire_q, bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      bubble_q <= '0;
    end else if (valid_q) begin
      retire_q <= retire_q + 1'b1;
    end else begin
      bubble_q <= bubble_q + 1'b1;
    end
  end

  assign retire_count = retire_q;
  assign bubble_count = bubble_q;
`else
  assign retire_count = '0;
  assign bubble_count = '0;
`endif

endmodule
